ibuf_skew: RTL and testbench

Parametrised input skew buffer for the systolic MAC array. It holds one DEPTH-element operand vector per array row (lane), loaded a whole lane at a time. On start it streams the lanes into the array with a one-cycle stagger per lane, and it drives per-lane valids and a done pulse. It sits between the operand loader and the array's west edge, and generalises the fixed 4-lane, 8-bit, 4-deep input buffer to arbitrary geometry. It adds a ready/busy handshake, non-destructive replay and optional double buffering.

---
 rtl/ibuf_skew.sv | 139 +++++++++++++
 tb/tb_ibuf_skew.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_skew.sv
// Input skew buffer: streams one DEPTH-element vector per lane with a one-cycle stagger per lane.
// Define IBUF_DBUF_EN to add a shadow bank that takes loads while the active bank streams.
module ibuf_skew #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int TW    = 4,
    localparam int AW   = (N > 1) ? $clog2(N) : 1,
    localparam int CW   = $clog2(DEPTH + N - 1),
    localparam int EW   = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  LOAD_EN,
    input  logic [AW-1:0]         LOAD_DST,
    input  logic [DEPTH*DW-1:0]   LOAD_WORD,
    output logic                  LOAD_READY,
    input  logic                  START_CALC,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [N*DW-1:0]       IROW_o,
    output logic [N-1:0]          ICOL_VALID,
    input  logic [TW-1:0]         ODST_i,
    output logic [TW-1:0]         ODST_o
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    localparam logic [CW-1:0] C_LAST = CW'(DEPTH + N - 2);

    state_e          state_q;
    logic [CW-1:0]   c_q;
    logic [TW-1:0]   odst_q;
    logic [DW-1:0]   act_q [N][DEPTH];
    logic            start_acc;
    logic            dst_ok;

    assign start_acc = (state_q == S_IDLE) && START_CALC;
    assign dst_ok    = (32'(LOAD_DST) < 32'(N));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            c_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START_CALC) begin
                        state_q <= S_RUN;
                        c_q     <= '0;
                    end
                end
                S_RUN: begin
                    if (c_q == C_LAST) begin
                        state_q <= S_IDLE;
                        c_q     <= '0;
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef IBUF_DBUF_EN
    logic [DW-1:0] shd_q [N][DEPTH];

    assign LOAD_READY = 1'b1;

    // Copy and load share one edge: active takes the old shadow, the new word goes to the next pass.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    act_q[i][j] <= '0;
                    shd_q[i][j] <= '0;
                end
            end
        end else begin
            if (start_acc) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        act_q[i][j] <= shd_q[i][j];
                    end
                end
            end
            if (LOAD_EN && dst_ok) begin
                for (int j = 0; j < DEPTH; j++) begin
                    shd_q[LOAD_DST][j] <= LOAD_WORD[j*DW +: DW];
                end
            end
        end
    end
`else
    assign LOAD_READY = (state_q == S_IDLE) && !START_CALC;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    act_q[i][j] <= '0;
                end
            end
        end else if (LOAD_EN && LOAD_READY && dst_ok) begin
            for (int j = 0; j < DEPTH; j++) begin
                act_q[LOAD_DST][j] <= LOAD_WORD[j*DW +: DW];
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            odst_q <= '0;
        end else begin
            odst_q <= ODST_i;
        end
    end

    assign ODST_o = odst_q;
    assign BUSY   = (state_q == S_RUN);
    assign DONE   = (state_q == S_RUN) && (c_q == C_LAST);

    // Lane i shows element c-i inside its window; comparisons carry one extra bit so i+DEPTH never wraps.
    always_comb begin
        IROW_o     = '0;
        ICOL_VALID = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_q == S_RUN) &&
                ({1'b0, c_q} >= (CW+1)'(i)) &&
                ({1'b0, c_q} <  (CW+1)'(i + DEPTH))) begin
                ICOL_VALID[i]       = 1'b1;
                IROW_o[i*DW +: DW]  = act_q[i][EW'(c_q - CW'(i))];
            end
        end
    end

endmodule

// File: tb/tb_ibuf_skew.sv
// Self-checking bench for ibuf_skew: default 4-lane instance plus a 5-lane instance for bad destinations.
module tb_ibuf_skew;

  localparam int N = 4;
  localparam int N5 = 5;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TW = 4;
  localparam int PASS_LEN = DEPTH + N - 1;
  localparam int PASS_LEN5 = DEPTH + N5 - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-lane instance
  logic              load_en;
  logic [1:0]        load_dst;
  logic [DEPTH*DW-1:0] load_word;
  logic              load_ready;
  logic              start_calc;
  logic              busy;
  logic              done;
  logic [N*DW-1:0]   irow;
  logic [N-1:0]      icol_valid;
  logic [TW-1:0]     odst_i;
  logic [TW-1:0]     odst_o;

  // 5-lane instance
  logic              load_en5;
  logic [2:0]        load_dst5;
  logic [DEPTH*DW-1:0] load_word5;
  logic              load_ready5;
  logic              start_calc5;
  logic              busy5;
  logic              done5;
  logic [N5*DW-1:0]  irow5;
  logic [N5-1:0]     icol_valid5;
  logic [TW-1:0]     odst_o5;

  ibuf_skew #(.N(N), .DW(DW), .DEPTH(DEPTH), .TW(TW)) u_dut (
    .CLK(clk), .RSTN(rst_n), .LOAD_EN(load_en), .LOAD_DST(load_dst), .LOAD_WORD(load_word),
    .LOAD_READY(load_ready), .START_CALC(start_calc), .BUSY(busy), .DONE(done),
    .IROW_o(irow), .ICOL_VALID(icol_valid), .ODST_i(odst_i), .ODST_o(odst_o)
  );

  ibuf_skew #(.N(N5), .DW(DW), .DEPTH(DEPTH), .TW(TW)) u_dut5 (
    .CLK(clk), .RSTN(rst_n), .LOAD_EN(load_en5), .LOAD_DST(load_dst5), .LOAD_WORD(load_word5),
    .LOAD_READY(load_ready5), .START_CALC(start_calc5), .BUSY(busy5), .DONE(done5),
    .IROW_o(irow5), .ICOL_VALID(icol_valid5), .ODST_i(4'h0), .ODST_o(odst_o5)
  );

  int checks = 0;
  int failures = 0;

  // reference model: what each lane holds, as element arrays
  logic [DW-1:0] m_act [N][DEPTH];
  logic [DW-1:0] m_shd [N][DEPTH];
  logic [DW-1:0] m5 [N5][DEPTH];

  logic [N*DW-1:0] cap_row [PASS_LEN];
  logic [N-1:0]    cap_val [PASS_LEN];
  logic            cap_done [PASS_LEN];

  logic [TW-1:0] exp_q[$];

  function automatic void model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < DEPTH; j++) begin
        m_act[i][j] = '0;
        m_shd[i][j] = '0;
      end
    for (int i = 0; i < N5; i++)
      for (int j = 0; j < DEPTH; j++) m5[i][j] = '0;
  endfunction

  function automatic void model_load(input int dst, input logic [DEPTH*DW-1:0] w);
    for (int j = 0; j < DEPTH; j++) begin
`ifdef IBUF_DBUF_EN
      m_shd[dst][j] = w[j*DW +: DW];
`else
      m_act[dst][j] = w[j*DW +: DW];
`endif
    end
  endfunction

  function automatic void model_start();
`ifdef IBUF_DBUF_EN
    for (int i = 0; i < N; i++)
      for (int j = 0; j < DEPTH; j++) m_act[i][j] = m_shd[i][j];
`endif
  endfunction

  // driver tasks
  task automatic do_load(input int dst, input logic [DEPTH*DW-1:0] w);
    load_en = 1'b1;
    load_dst = 2'(dst);
    load_word = w;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_idle got=%b exp=1", load_ready);
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    model_load(dst, w);
  endtask

  task automatic start_pass();
    start_calc = 1'b1;
    model_start();
    @(posedge clk); #1;
    start_calc = 1'b0;
  endtask

  // Called at c=0 of an accepted pass; checks every cycle and the first idle cycle.
  task automatic stream_check(input string name, input bit mid_start);
    logic [N*DW-1:0] er;
    logic [N-1:0] ev;
    for (int c = 0; c < PASS_LEN; c++) begin
      er = '0;
      ev = '0;
      for (int i = 0; i < N; i++) begin
        if (c >= i && c < i + DEPTH) begin
          ev[i] = 1'b1;
          er[i*DW +: DW] = m_act[i][c-i];
        end
      end
      cap_row[c] = irow;
      cap_val[c] = icol_valid;
      cap_done[c] = done;
      checks++;
      if (irow !== er || icol_valid !== ev || busy !== 1'b1 || done !== (c == PASS_LEN - 1)) begin
        failures++;
        $display("FAIL %s c=%0d irow=%h exp=%h valid=%b exp=%b busy=%b done=%b exp_done=%0d",
                 name, c, irow, er, icol_valid, ev, busy, done, (c == PASS_LEN - 1));
      end
      if (mid_start) start_calc = (c == 2);
      @(posedge clk); #1;
    end
    if (mid_start) start_calc = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || icol_valid !== '0 || irow !== '0) begin
      failures++;
      $display("FAIL %s_idle busy=%b done=%b valid=%b irow=%h exp all zero", name, busy, done, icol_valid, irow);
    end
  endtask

  task automatic stream_check5(input string name);
    logic [N5*DW-1:0] er;
    logic [N5-1:0] ev;
    start_calc5 = 1'b1;
    @(posedge clk); #1;
    start_calc5 = 1'b0;
    for (int c = 0; c < PASS_LEN5; c++) begin
      er = '0;
      ev = '0;
      for (int i = 0; i < N5; i++) begin
        if (c >= i && c < i + DEPTH) begin
          ev[i] = 1'b1;
          er[i*DW +: DW] = m5[i][c-i];
        end
      end
      checks++;
      if (irow5 !== er || icol_valid5 !== ev || done5 !== (c == PASS_LEN5 - 1)) begin
        failures++;
        $display("FAIL %s c=%0d irow=%h exp=%h valid=%b exp=%b done=%b", name, c, irow5, er, icol_valid5, ev, done5);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy5 !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle busy=%b exp=0", name, busy5);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    #1;
    checks++;
    if (irow !== '0 || icol_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || odst_o !== '0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state irow=%h valid=%b busy=%b done=%b odst=%h ready=%b exp 0/0/0/0/0/1",
               irow, icol_valid, busy, done, odst_o, load_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_load(0, 32'h14131211);
    do_load(1, 32'h24232221);
    do_load(2, 32'h34333231);
    do_load(3, 32'h44434241);
    start_pass();
    stream_check("basic", 1'b0);
    checks++;
    if (cap_row[0] !== 32'h00000011 || cap_val[0] !== 4'b0001) begin
      failures++; $display("FAIL basic_c0 irow=%h valid=%b exp=00000011/0001", cap_row[0], cap_val[0]);
    end
    checks++;
    if (cap_row[1] !== 32'h00002112 || cap_val[1] !== 4'b0011) begin
      failures++; $display("FAIL basic_c1 irow=%h valid=%b exp=00002112/0011", cap_row[1], cap_val[1]);
    end
    checks++;
    if (cap_row[3] !== 32'h41322314 || cap_val[3] !== 4'b1111) begin
      failures++; $display("FAIL basic_c3 irow=%h valid=%b exp=41322314/1111", cap_row[3], cap_val[3]);
    end
    checks++;
    if (cap_row[6] !== 32'h44000000 || cap_val[6] !== 4'b1000 || cap_done[6] !== 1'b1) begin
      failures++; $display("FAIL basic_c6 irow=%h valid=%b done=%b exp=44000000/1000/1", cap_row[6], cap_val[6], cap_done[6]);
    end
  endtask

  task automatic test_replay();
    logic [N*DW-1:0] ref_row [PASS_LEN];
    logic [N-1:0] ref_val [PASS_LEN];
    for (int c = 0; c < PASS_LEN; c++) begin
      ref_row[c] = cap_row[c];
      ref_val[c] = cap_val[c];
    end
    start_pass();
    stream_check("replay", 1'b1);
    for (int c = 0; c < PASS_LEN; c++) begin
      checks++;
      if (cap_row[c] !== ref_row[c] || cap_val[c] !== ref_val[c]) begin
        failures++;
        $display("FAIL replay_same c=%0d irow=%h exp=%h valid=%b exp=%b", c, cap_row[c], ref_row[c], cap_val[c], ref_val[c]);
      end
    end
  endtask

  task automatic test_collision();
    logic exp_ready;
    logic [DW-1:0] exp_next;
`ifdef IBUF_DBUF_EN
    exp_ready = 1'b1;
    exp_next = 8'hAA;
`else
    exp_ready = 1'b0;
    exp_next = 8'h11;
`endif
    start_calc = 1'b1;
    load_en = 1'b1;
    load_dst = 2'd0;
    load_word = 32'hAAAAAAAA;
    #1;
    checks++;
    if (load_ready !== exp_ready) begin
      failures++; $display("FAIL collide_ready got=%b exp=%b", load_ready, exp_ready);
    end
    model_start();
`ifdef IBUF_DBUF_EN
    for (int j = 0; j < DEPTH; j++) m_shd[0][j] = 8'hAA;
`endif
    @(posedge clk); #1;
    start_calc = 1'b0;
    load_en = 1'b0;
    stream_check("collide", 1'b0);
    checks++;
    if (cap_row[0][7:0] !== 8'h11) begin
      failures++; $display("FAIL collide_c0 lane0=%h exp=11", cap_row[0][7:0]);
    end
    start_pass();
    stream_check("collide_next", 1'b0);
    checks++;
    if (cap_row[0][7:0] !== exp_next) begin
      failures++; $display("FAIL collide_next_c0 lane0=%h exp=%h", cap_row[0][7:0], exp_next);
    end
  endtask

  task automatic test_back_to_back();
    int budget;
    start_calc = 1'b1;
    model_start();
    @(posedge clk); #1;
    stream_check("b2b", 1'b0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || icol_valid !== 4'b0001 || irow !== {24'h0, m_act[0][0]}) begin
      failures++;
      $display("FAIL b2b_restart busy=%b valid=%b irow=%h exp=1/0001/%h", busy, icol_valid, irow, {24'h0, m_act[0][0]});
    end
    start_calc = 1'b0;
    budget = 0;
    while (busy === 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_drain busy=%b exp=0 after %0d cycles", busy, budget);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nl = $urandom_range(1, 4);
      for (int k = 0; k < nl; k++) do_load($urandom_range(0, N - 1), $urandom);
      start_pass();
      stream_check("random", 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_bad_dst();
    for (int i = 0; i < N5; i++) begin
      logic [DEPTH*DW-1:0] w = $urandom;
      load_en5 = 1'b1; load_dst5 = 3'(i); load_word5 = w;
      @(posedge clk); #1;
      for (int j = 0; j < DEPTH; j++) m5[i][j] = w[j*DW +: DW];
    end
    load_en5 = 1'b0;
    stream_check5("n5_base");
    for (int d = 5; d < 8; d++) begin
      load_en5 = 1'b1; load_dst5 = 3'(d); load_word5 = $urandom;
      #1;
      checks++;
      if (load_ready5 !== 1'b1) begin
        failures++; $display("FAIL n5_ready got=%b exp=1", load_ready5);
      end
      @(posedge clk); #1;
    end
    load_en5 = 1'b0;
    stream_check5("n5_bad_dst");
  endtask

  task automatic test_odst();
    logic [TW-1:0] e;
    for (int k = 0; k < 16; k++) begin
      logic [TW-1:0] v = TW'($urandom);
      odst_i = v;
      exp_q.push_back(v);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (odst_o !== e) begin
        failures++; $display("FAIL odst k=%0d got=%h exp=%h", k, odst_o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    odst_i = 4'hF;
    start_pass();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (icol_valid !== 4'b1111) begin
      failures++; $display("FAIL rmid_c3 valid=%b exp=1111", icol_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (icol_valid !== '0 || busy !== 1'b0 || done !== 1'b0 || irow !== '0 || odst_o !== '0) begin
      failures++;
      $display("FAIL rmid_async valid=%b busy=%b done=%b irow=%h odst=%h exp all zero", icol_valid, busy, done, irow, odst_o);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL rmid_hold done=%b busy=%b exp=0/0", done, busy);
      end
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_pass();
    stream_check("post_reset", 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = 1'b0; load_dst = '0; load_word = '0; start_calc = 1'b0; odst_i = '0;
    load_en5 = 1'b0; load_dst5 = '0; load_word5 = '0; start_calc5 = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_replay();
    test_collision();
    test_back_to_back();
    test_random();
    test_bad_dst();
    test_odst();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
